// File: rtl/mem_stage_pkg.sv
// Shared RISC-V encodings used by the memory stage: funct3 access sizes,
// writeback-select codes and the size decode helper.
package mem_stage_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    M2R_ALU = 2'b00,
    M2R_MEM = 2'b01,
    M2R_PC4 = 2'b10
  } mem2reg_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  // Reserved encodings 011/110/111 fall through to word size.
  function automatic size_e size_of(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_load_store_align.sv
// Lane extraction, sign/zero extension, store byte enables and misalign
// detection for one data-memory access. Purely combinational.
module load_store_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [31:0] rd_word_i,
  input  logic [31:0] wdata_i,
  output logic        misalign_o,
  output logic [31:0] load_data_o,
  output logic [3:0]  byte_en_o,
  output logic [31:0] wr_word_o
);

  size_e       size;
  logic        is_unsigned;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic signed [31:0] ext;

  assign size        = size_of(funct3_i);
  assign is_unsigned = (funct3_i == F3_BU) || (funct3_i == F3_HU);

  always_comb begin
    misalign_o = 1'b0;
    if (mem_read_i || mem_write_i) begin
      case (size)
        SZ_H:    misalign_o = addr_lo_i[0];
        SZ_W:    misalign_o = (addr_lo_i != 2'b00);
        default: misalign_o = 1'b0;
      endcase
    end
  end

  always_comb begin
    lane_b = 8'h00;
    case (addr_lo_i)
      2'd0:    lane_b = rd_word_i[7:0];
      2'd1:    lane_b = rd_word_i[15:8];
      2'd2:    lane_b = rd_word_i[23:16];
      default: lane_b = rd_word_i[31:24];
    endcase
    lane_h = addr_lo_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];
  end

  always_comb begin
    ext = $signed(rd_word_i);
    case (size)
      SZ_B: ext = is_unsigned ? $signed({24'h0, lane_b}) : $signed({{24{lane_b[7]}}, lane_b});
      SZ_H: ext = is_unsigned ? $signed({16'h0, lane_h}) : $signed({{16{lane_h[15]}}, lane_h});
      default: ext = $signed(rd_word_i);
    endcase
  end

  // A misaligned load returns zero rather than a partial lane.
  assign load_data_o = (mem_read_i && !misalign_o) ? $unsigned(ext) : 32'h0;

  always_comb begin
    byte_en_o = 4'b0000;
    wr_word_o = wdata_i;
    case (size)
      SZ_B: begin
        byte_en_o = 4'b0001 << addr_lo_i;
        wr_word_o = {4{wdata_i[7:0]}};
      end
      SZ_H: begin
        byte_en_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wr_word_o = {2{wdata_i[15:0]}};
      end
      default: begin
        byte_en_o = 4'b1111;
        wr_word_o = wdata_i;
      end
    endcase
    if (!mem_write_i || misalign_o) byte_en_o = 4'b0000;
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: data memory array with combinational load path and the
// MEM/WB pipeline register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] read_Address_EXMEM,
  input  logic [31:0] write_Data_EXMEM,
  input  logic [2:0]  funct3_EXMEM,
  input  logic [31:0] PC_plus4_EXMEM,
  input  logic [4:0]  rd_EXMEM,
  input  logic [1:0]  mem2reg_EXMEM,
  input  logic        RegWrite_EXMEM,
  input  logic        memRead_EXMEM,
  input  logic        memWrite_EXMEM,
  output logic [31:0] memData_Out_MEM,
  output logic [31:0] read_data_MEMWB,
  output logic [31:0] alu_result_MEMWB,
  output logic [31:0] PC_plus4_MEMWB,
  output logic [4:0]  rd_MEMWB,
  output logic [1:0]  mem2reg_MEMWB,
  output logic        RegWrite_MEMWB,
  output logic        misalign_MEM
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem_q [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic [31:0]   rd_word;
  logic [31:0]   wr_word;
  logic [3:0]    byte_en;

  assign idx     = read_Address_EXMEM[AW+1:2];
  assign rd_word = mem_q[idx];

  load_store_align u_align (
    .addr_lo_i   (read_Address_EXMEM[1:0]),
    .funct3_i    (funct3_EXMEM),
    .mem_read_i  (memRead_EXMEM),
    .mem_write_i (memWrite_EXMEM),
    .rd_word_i   (rd_word),
    .wdata_i     (write_Data_EXMEM),
    .misalign_o  (misalign_MEM),
    .load_data_o (memData_Out_MEM),
    .byte_en_o   (byte_en),
    .wr_word_o   (wr_word)
  );

  // Array is never cleared; rst_n only gates the write so contents survive reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (byte_en[0]) mem_q[idx][7:0]   <= wr_word[7:0];
      if (byte_en[1]) mem_q[idx][15:8]  <= wr_word[15:8];
      if (byte_en[2]) mem_q[idx][23:16] <= wr_word[23:16];
      if (byte_en[3]) mem_q[idx][31:24] <= wr_word[31:24];
    end
  end

  logic [31:0] read_data_q, alu_result_q, pc4_q;
  logic [31:0] read_data_d, alu_result_d, pc4_d;
  logic [4:0]  rd_q, rd_d;
  logic [1:0]  m2r_q, m2r_d;
  logic        regwrite_q, regwrite_d;

  always_comb begin
    read_data_d  = memData_Out_MEM;
    alu_result_d = read_Address_EXMEM;
    pc4_d        = PC_plus4_EXMEM;
    rd_d         = rd_EXMEM;
    m2r_d        = mem2reg_EXMEM;
    regwrite_d   = RegWrite_EXMEM;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_data_q  <= 32'h0;
      alu_result_q <= 32'h0;
      pc4_q        <= 32'h0;
      rd_q         <= 5'h0;
      m2r_q        <= 2'h0;
      regwrite_q   <= 1'b0;
    end else begin
      read_data_q  <= read_data_d;
      alu_result_q <= alu_result_d;
      pc4_q        <= pc4_d;
      rd_q         <= rd_d;
      m2r_q        <= m2r_d;
      regwrite_q   <= regwrite_d;
    end
  end

  assign read_data_MEMWB  = read_data_q;
  assign alu_result_MEMWB = alu_result_q;
  assign PC_plus4_MEMWB   = pc4_q;
  assign rd_MEMWB         = rd_q;
  assign mem2reg_MEMWB    = m2r_q;
  assign RegWrite_MEMWB   = regwrite_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed load/store scenarios, reset behaviour and a
// randomized run against a word-array reference model.
module tb_mem_stage;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr, wdata, pc4;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic [1:0]  m2r;
  logic        regwr, mrd, mwr;
  logic [31:0] mem_out, rdata_wb, alu_wb, pc4_wb;
  logic [4:0]  rd_wb;
  logic [1:0]  m2r_wb;
  logic        regwr_wb, mis;

  int n_vec  = 0;
  int n_fail = 0;

  logic [31:0] ref_mem [DEPTH];

  mem_stage #(.DEPTH_WORDS(DEPTH)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .read_Address_EXMEM (addr),
    .write_Data_EXMEM   (wdata),
    .funct3_EXMEM       (f3),
    .PC_plus4_EXMEM     (pc4),
    .rd_EXMEM           (rd),
    .mem2reg_EXMEM      (m2r),
    .RegWrite_EXMEM     (regwr),
    .memRead_EXMEM      (mrd),
    .memWrite_EXMEM     (mwr),
    .memData_Out_MEM    (mem_out),
    .read_data_MEMWB    (rdata_wb),
    .alu_result_MEMWB   (alu_wb),
    .PC_plus4_MEMWB     (pc4_wb),
    .rd_MEMWB           (rd_wb),
    .mem2reg_MEMWB      (m2r_wb),
    .RegWrite_MEMWB     (regwr_wb),
    .misalign_MEM       (mis)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic int word_idx(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  function automatic bit ref_mis(input logic [31:0] a, input logic [2:0] fn, input bit access);
    if (!access) return 0;
    if (fn == 3'd0 || fn == 3'd4) return 0;
    if (fn == 3'd1 || fn == 3'd5) return (a % 2) != 0;
    return (a % 4) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] fn);
    logic [31:0] w, v;
    int k;
    w = ref_mem[word_idx(a)];
    k = int'(a % 4);
    case (fn)
      3'd0, 3'd4: begin
        v = (w >> (8 * k)) & 32'hFF;
        if (fn == 3'd0 && v >= 32'd128) v = v | 32'hFFFF_FF00;
      end
      3'd1, 3'd5: begin
        v = (w >> (16 * (k / 2))) & 32'hFFFF;
        if (fn == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] fn);
    logic [31:0] mask;
    int k, sh;
    k = int'(a % 4);
    if (fn == 3'd0 || fn == 3'd4) begin
      sh = 8 * k; mask = 32'hFF << sh;
    end else if (fn == 3'd1 || fn == 3'd5) begin
      sh = 16 * (k / 2); mask = 32'hFFFF << sh;
    end else begin
      sh = 0; mask = 32'hFFFF_FFFF;
    end
    ref_mem[word_idx(a)] = (ref_mem[word_idx(a)] & ~mask) | ((d << sh) & mask);
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic op(input string tag, input logic [31:0] a, input logic [31:0] d,
                    input logic [2:0] fn, input bit r, input bit w,
                    input logic [4:0] rdi, input bit rw, input logic [1:0] mm,
                    input logic [31:0] pc);
    logic [31:0] exp_ld;
    bit exp_mis;
    addr = a; wdata = d; f3 = fn; mrd = r; mwr = w;
    rd = rdi; regwr = rw; m2r = mm; pc4 = pc;
    #1;
    exp_mis = ref_mis(a, fn, r || w);
    exp_ld  = (r && !exp_mis) ? ref_load(a, fn) : 32'h0;
    chk({tag, ".mis"}, {31'h0, mis}, {31'h0, exp_mis});
    chk({tag, ".ld"}, mem_out, exp_ld);
    @(posedge clk);
    #1;
    if (w && !exp_mis) ref_store(a, d, fn);
    chk({tag, ".wb_rdata"}, rdata_wb, exp_ld);
    chk({tag, ".wb_alu"}, alu_wb, a);
    chk({tag, ".wb_ctl"}, {pc4_wb[23:0], rd_wb, m2r_wb, regwr_wb},
        {pc[23:0], rdi, mm, rw});
    @(negedge clk);
  endtask

  task automatic chk_wb_zero(input string tag);
    chk({tag, ".rdata"}, rdata_wb, 32'h0);
    chk({tag, ".alu"}, alu_wb, 32'h0);
    chk({tag, ".pc4"}, pc4_wb, 32'h0);
    chk({tag, ".ctl"}, {24'h0, rd_wb, m2r_wb, regwr_wb}, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    addr = '0; wdata = '0; f3 = '0; pc4 = '0; rd = '0; m2r = '0;
    regwr = 1'b0; mrd = 1'b0; mwr = 1'b0;
    repeat (2) @(negedge clk);
    chk_wb_zero("reset");
    rst_n = 1'b1;

    // Fill the whole array so every later load has a defined expectation.
    for (int i = 0; i < DEPTH; i++)
      op("fill", 32'(i * 4), $urandom, 3'b010, 0, 1, 5'd1, 0, 2'd0, 32'h100);

    op("sw10", 32'h10, 32'hDEADBEEF, 3'b010, 0, 1, 5'd0, 0, 2'd0, 32'h4);
    op("lw10", 32'h10, 32'h0, 3'b010, 1, 0, 5'd3, 1, 2'd1, 32'h8);
    chk("lw10.value", rdata_wb, 32'hDEADBEEF);
    op("lb13", 32'h13, 32'h0, 3'b000, 1, 0, 5'd3, 1, 2'd1, 32'hC);
    chk("lb13.value", rdata_wb, 32'hFFFFFFDE);
    op("lbu13", 32'h13, 32'h0, 3'b100, 1, 0, 5'd3, 1, 2'd1, 32'h10);
    chk("lbu13.value", rdata_wb, 32'h000000DE);
    op("lh12", 32'h12, 32'h0, 3'b001, 1, 0, 5'd3, 1, 2'd1, 32'h14);
    chk("lh12.value", rdata_wb, 32'hFFFFDEAD);
    op("lhu10", 32'h10, 32'h0, 3'b101, 1, 0, 5'd3, 1, 2'd1, 32'h18);
    chk("lhu10.value", rdata_wb, 32'h0000BEEF);
    op("sb11", 32'h11, 32'h12, 3'b000, 0, 1, 5'd0, 0, 2'd0, 32'h1C);
    op("lw10b", 32'h10, 32'h0, 3'b010, 1, 0, 5'd4, 1, 2'd1, 32'h20);
    chk("lw10b.value", rdata_wb, 32'hDEAD12EF);
    op("sw22mis", 32'h22, 32'h11111111, 3'b010, 0, 1, 5'd0, 0, 2'd0, 32'h24);
    op("lw20", 32'h20, 32'h0, 3'b010, 1, 0, 5'd5, 1, 2'd1, 32'h28);
    op("lh13mis", 32'h13, 32'h0, 3'b001, 1, 0, 5'd5, 1, 2'd1, 32'h2C);
    op("sw400", 32'h400, 32'hA5A5A5A5, 3'b010, 0, 1, 5'd0, 0, 2'd0, 32'h30);
    op("lw000", 32'h000, 32'h0, 3'b010, 1, 0, 5'd6, 1, 2'd1, 32'h34);
    chk("lw000.value", rdata_wb, 32'hA5A5A5A5);
    op("rdwr", 32'h40, 32'h5555AAAA, 3'b010, 1, 1, 5'd8, 1, 2'd1, 32'h38);
    op("lw40", 32'h40, 32'h0, 3'b010, 1, 0, 5'd8, 1, 2'd1, 32'h3C);
    chk("lw40.value", rdata_wb, 32'h5555AAAA);

    // Asynchronous reset mid-cycle, then a store attempted while held in reset.
    addr = 32'h44; mrd = 1'b0; mwr = 1'b0; rd = 5'd7; regwr = 1'b1;
    m2r = 2'd2; pc4 = 32'h44;
    @(posedge clk);
    #2;
    chk("pre_rst.rd", {27'h0, rd_wb}, 32'd7);
    rst_n = 1'b0;
    #1;
    chk_wb_zero("async_rst");
    @(negedge clk);
    addr = 32'h10; wdata = 32'h0BADF00D; f3 = 3'b010; mwr = 1'b1;
    @(posedge clk);
    #1;
    chk_wb_zero("held_rst");
    @(negedge clk);
    mwr = 1'b0;
    rst_n = 1'b1;
    op("lw10post", 32'h10, 32'h0, 3'b010, 1, 0, 5'd9, 1, 2'd1, 32'h48);
    chk("lw10post.value", rdata_wb, 32'hDEAD12EF);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] ra;
      logic [2:0]  rf;
      int kind;
      ra = $urandom_range(0, 32'h7FF);
      rf = 3'($urandom_range(0, 7));
      kind = $urandom_range(0, 3);
      op("rand", ra, $urandom, rf, kind == 1 || kind == 3, kind == 2 || kind == 3,
         5'($urandom), 1'($urandom), 2'($urandom_range(0, 2)), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, meaning data-memory depth in 32-bit words (power of two, 16..4096).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port read_Address_EXMEM  input  32  ALU result: byte address for load/store, or the ALU value for writeback.
REQ-005 SHALL have port write_Data_EXMEM  input  32  store data (forwarded rs2).
REQ-006 SHALL have port funct3_EXMEM  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 SHALL have ports PC_plus4_EXMEM  input  32; rd_EXMEM  input  5; mem2reg_EXMEM  input  2; RegWrite_EXMEM  input  1; memRead_EXMEM  input  1; memWrite_EXMEM  input  1: EX/MEM register contents.
REQ-008 SHALL have port memData_Out_MEM  output  32  combinational load data, forwarded to EX (ForwardA/B = 01).
REQ-009 SHALL have ports read_data_MEMWB  output  32; alu_result_MEMWB  output  32; PC_plus4_MEMWB  output  32; rd_MEMWB  output  5; mem2reg_MEMWB  output  2; RegWrite_MEMWB  output  1: MEM/WB register.
REQ-010 SHALL have port misalign_MEM  output  1  combinational flag: current access is misaligned.

Function
REQ-011 SHALL hold a DEPTH_WORDS x 32 array indexed by read_Address_EXMEM[log2(DEPTH_WORDS)+1:2]; higher address bits ignored (address wraps modulo 4*DEPTH_WORDS).
REQ-012 SHALL read combinationally: with memRead_EXMEM=1, memData_Out_MEM = extracted, extended lane of the addressed word; with memRead_EXMEM=0, memData_Out_MEM = 0.
REQ-013 SHALL extract lanes little-endian: byte k = bits [8k+7:8k] for addr[1:0]=k; halfword at addr[1]; B/H sign-extend, BU/HU zero-extend, W unchanged.
REQ-014 SHALL write on posedge clk when memWrite_EXMEM=1 and not misaligned, byte enables: SB one byte at addr[1:0], SH two bytes at addr[1], SW all four; unselected bytes unchanged.
REQ-015 SHALL flag misalign_MEM=1 when (memRead_EXMEM|memWrite_EXMEM) and (H/HU with addr[0]=1, or W with addr[1:0]!=0); misaligned store suppressed, misaligned load returns 0.
REQ-016 SHALL treat funct3 011/110/111 with an access as W size (no trap).
REQ-017 SHALL, if memRead_EXMEM and memWrite_EXMEM are both 1, perform the write and return pre-write data on memData_Out_MEM in that cycle.
REQ-018 SHALL make a store at cycle N visible to a load of the same address in cycle N+1 (no read-during-write bypass needed within a cycle).
REQ-019 SHALL register on every posedge clk: read_data_MEMWB<=memData_Out_MEM, alu_result_MEMWB<=read_Address_EXMEM, PC_plus4/rd/mem2reg/RegWrite passed through; latency exactly 1 cycle, no stall or enable.
REQ-020 SHALL not alter RegWrite_MEMWB on misalignment (pass-through).

Reset
REQ-021 SHALL clear every MEM/WB output to 0 immediately on rst_n low, independent of clk.
REQ-022 SHALL NOT reset the memory array; contents persist across reset; writes blocked while rst_n=0.
REQ-023 SHALL resume normal registering on the first posedge after rst_n rises; reset mid-store: store not committed if rst_n low at that edge.

Structure
REQ-024 SHALL take funct3 size encodings and mem2reg codes (00 ALU, 01 mem, 10 PC+4) from the shared riscv package.
REQ-025 SHALL isolate lane extraction, extension, byte-enable and misalign logic in one combinational sub-module load_store_align; array and MEM/WB register live in mem_stage.

Verification
REQ-026 SW 0xDEADBEEF @0x10, next cycle LW @0x10 -> memData_Out_MEM=0xDEADBEEF, read_data_MEMWB=0xDEADBEEF one cycle later.
REQ-027 After REQ-026, LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD; LHU @0x10 -> 0x0000BEEF.
REQ-028 SB 0x12 @0x11 over 0xDEADBEEF -> LW @0x10 = 0xDEAD12EF.
REQ-029 SW 0x11111111 @0x22 -> misalign_MEM=1, LW @0x20 unchanged; LH @0x13 -> misalign_MEM=1, data 0.
REQ-030 DEPTH_WORDS=256: SW 0xA5A5A5A5 @0x400 -> LW @0x000 = 0xA5A5A5A5 (wrap).
REQ-031 rd=7, RegWrite=1, then rst_n low mid-cycle -> all MEM/WB outputs 0 before next edge; memory word @0x10 retained after reset.
